// File: rtl/sa_acc_drain.sv
// sa_acc_drain: result-drain engine at the output edge of one systolic-array column.
//
// Snapshots the per-row FP32 PE results into shadow registers. On drain_req it waits
// MAC_LAT cycles so that in-flight MACs can settle. It then pulses clr_acc to the PEs and
// streams the frozen snapshot one row per beat over a valid/ready master port.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   drain_req            pulse to start a drain; only accepted in idle
//   busy                 high in every state except idle
//   drain_done           one-cycle pulse after the last beat is accepted
//   pe_valid, pe_y       per-row PE result valid and data (row r = pe_y[32*r+:32])
//   clr_acc              one-cycle pulse that clears the PE accumulators
//   m_valid/m_ready      stream handshake
//   m_data/m_row/m_last  beat payload (FP32 word, row index, last-row flag)
//   drop_err             sticky: a PE result arrived while the shadow was frozen
//
// Optional feature macro SA_DRAIN_EXC_FLAG_EN adds these outputs:
//   m_exc                beat carries Inf/NaN (exponent field all ones)
//   exc_sticky           set by any transferred beat with m_exc; cleared on an accepted drain_req

module sa_acc_drain #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned MAC_LAT = 5,
  localparam int unsigned RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drain_req,
  output logic             busy,
  output logic             drain_done,
  input  logic [ROWS-1:0]  pe_valid,
  input  logic [ROWS*32-1:0] pe_y,
  output logic             clr_acc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic [RW-1:0]    m_row,
  output logic             m_last,
  output logic             drop_err
`ifdef SA_DRAIN_EXC_FLAG_EN
  ,
  output logic             m_exc,
  output logic             exc_sticky
`endif
);

  localparam int unsigned CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);
  localparam logic [CW-1:0] WaitInit = CW'(MAC_LAT - 1);

  typedef enum logic [2:0] {StIdle, StWait, StClear, StStream, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [RW-1:0] row_q;
  logic [31:0]   shadow_q [ROWS];
  logic [RW-1:0] row_nxt;

  assign row_nxt = row_q + RW'(1);
  assign m_row   = row_q;

`ifdef SA_DRAIN_EXC_FLAG_EN
  function automatic logic is_exc(input logic [31:0] d);
    return d[30:23] == 8'hFF;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      row_q      <= '0;
      for (int r = 0; r < ROWS; r++) shadow_q[r] <= '0;
      busy       <= 1'b0;
      drain_done <= 1'b0;
      clr_acc    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      drop_err   <= 1'b0;
`ifdef SA_DRAIN_EXC_FLAG_EN
      m_exc      <= 1'b0;
      exc_sticky <= 1'b0;
`endif
    end else begin
      clr_acc    <= 1'b0;
      drain_done <= 1'b0;

      // Shadow tracks PE results until the tile is committed; afterwards late
      // results are dropped and flagged rather than corrupting the stream.
      if (state_q == StIdle || state_q == StWait) begin
        for (int r = 0; r < ROWS; r++) begin
          if (pe_valid[r]) shadow_q[r] <= pe_y[32*r +: 32];
        end
      end else if (|pe_valid) begin
        drop_err <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (drain_req) begin
            state_q    <= StWait;
            cnt_q      <= WaitInit;
            busy       <= 1'b1;
            drop_err   <= 1'b0;
`ifdef SA_DRAIN_EXC_FLAG_EN
            exc_sticky <= 1'b0;
`endif
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StClear;
            clr_acc <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        StClear: begin
          state_q <= StStream;
          row_q   <= '0;
          m_valid <= 1'b1;
          m_data  <= shadow_q[0];
          m_last  <= 1'b0;
`ifdef SA_DRAIN_EXC_FLAG_EN
          m_exc   <= is_exc(shadow_q[0]);
`endif
        end
        StStream: begin
          if (m_ready) begin
`ifdef SA_DRAIN_EXC_FLAG_EN
            if (m_exc) exc_sticky <= 1'b1;
`endif
            if (row_q == LastRow) begin
              state_q    <= StDone;
              drain_done <= 1'b1;
              m_valid    <= 1'b0;
              m_data     <= '0;
              m_last     <= 1'b0;
              row_q      <= '0;
`ifdef SA_DRAIN_EXC_FLAG_EN
              m_exc      <= 1'b0;
`endif
            end else begin
              row_q  <= row_nxt;
              m_data <= shadow_q[row_nxt];
              m_last <= (row_nxt == LastRow);
`ifdef SA_DRAIN_EXC_FLAG_EN
              m_exc  <= is_exc(shadow_q[row_nxt]);
`endif
            end
          end
        end
        StDone: begin
          for (int r = 0; r < ROWS; r++) shadow_q[r] <= '0;
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
